gpr_dumper: RTL
===============

# gpr_dumper

Debug read-out engine for the register file. On a start pulse it walks GPR addresses 0–31 through a dedicated GPR read port, appends the Flag register and a 32-bit additive checksum, and streams the 34 words out over a valid/ready handshake. It sits beside `GPR` and is used by the simulation harness and the debug UART bridge to capture architectural state once the core is halted.

## Interface

Parameters:
- None; word count and indices are fixed defines.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low: `reset==0` at a rising edge clears all state.
- `start`  in  1  request a dump; sampled only in IDLE.
- `RdAddr`  out  5  GPR read address, driven to a GPR combinational read port.
- `RdData`  in  32  GPR read data for `RdAddr`, combinational, same cycle.
- `Flag`  in  32  current Flag register value from GPR.
- `out_valid`  out  1  `out_data` / `out_index` hold a word.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready` at an edge.
- `out_data`  out  32  streamed word.
- `out_index`  out  6  0–31 = GPR index, 32 = Flag, 33 = checksum.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the checksum word is accepted.

## Operation

- State is held in `state`, `idx[5:0]` and `sum[31:0]`.
- `RdAddr = idx[4:0]` combinationally. When `idx >= 32`, the value on `RdAddr` is don't-care.
- The FSM has four states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - `busy = 0`.
  - If `start = 1`: `idx <= 0`, `sum <= 0`, go to FETCH.
- FETCH:
  - Load `out_data <= (idx<32) ? RdData : (idx==32) ? Flag : sum`.
  - `out_index <= idx`, `out_valid <= 1`, go to SEND.
- SEND:
  - Hold `out_data`, `out_index` and `out_valid` unchanged until handshake.
  - On handshake with `idx < 33`: `sum <= sum + out_data` (mod 2^32), `idx <= idx + 1`, `out_valid <= 0`, go to FETCH.
  - On handshake with `idx == 33`: `out_valid <= 0`, go to DONE.
- DONE:
  - `done = 1` for exactly this cycle, then go to IDLE.
- Checksum is the sum mod 2^32 of words 0–32: register 0 (always 0), registers 1–31, and Flag. The checksum itself is not added.
- `start` while `busy = 1` is ignored; it is neither queued nor allowed to restart the dump.
- Values are sampled in the FETCH cycle of each word. There is no snapshot coherency if the core writes the GPR during a dump; the core must be halted.
- Reset at any point, including mid-stream:
  - Next state is IDLE.
  - `out_valid = 0`, `out_data = 0`, `out_index = 0`, `idx = 0`, `sum = 0`, `done = 0`, `busy = 0`.
  - Any partially sent dump is abandoned with no `done`.

## Timing

- Reset values of outputs: `out_valid` 0, `out_data` 0, `out_index` 0, `busy` 0, `done` 0, `RdAddr` 0.
- `start` sampled high at edge E0 → FETCH during cycle E0–E1 → `out_valid = 1` after edge E1.
- Each word costs at least 2 cycles (FETCH + SEND). With `out_ready` held high, a full dump is 68 cycles from the first FETCH to the last handshake, and `done` is high in the cycle after that.
- `out_ready` may be low indefinitely; there is no timeout.
- `out_valid` never drops without a handshake, except on reset.
- `done` and `busy` are registered-state decodes (Moore outputs); there is no combinational path from `out_ready` to any output.
- A new `start` is accepted at the earliest in the cycle after `done`.

## Structure

- Shared defines header (alongside the existing `WR_EN` / `FLAG_OP_*` / `REG_ADDR_FLAG` defines):
  - `DUMP_WORDS = 34`, `DUMP_IDX_FLAG = 32`, `DUMP_IDX_CSUM = 33`.
  - 2-bit state encodings `DUMP_IDLE`, `DUMP_FETCH`, `DUMP_SEND`, `DUMP_DONE`.
- Single module; FSM, index counter and checksum accumulator are small enough that no sub-module is warranted.
- Integration: instantiated next to `GPR`, which gains a third combinational read port (`A3` / `RD3`) wired to `RdAddr` / `RdData`.

## Test plan

1. **Reset values.** Hold `reset = 0` for 3 edges with `start = 1` → all outputs 0, `busy = 0`, no dump starts.
2. **Full dump.** Preload GPR with reg[20] = 0xfedc1234, Flag = 0x1234cdef, all other registers 0; `out_ready = 1`; pulse `start` → 34 words:
   - index 20 = 0xfedc1234, index 32 = 0x1234cdef, index 33 = 0x1110e023, all others 0.
   - `done` pulses once, 69 cycles after the `start` edge.
3. **Back-pressure.** Same preload with `out_ready` toggled 1,0,0,1,… → identical word sequence and checksum. `out_data` / `out_index` are stable in every cycle with `out_valid && !out_ready`.
4. **Start while busy.** Pulse `start` again at index 10 → the stream continues unchanged from 11 to 33 with exactly one `done`.
5. **Reset mid-stream.** Drive `reset = 0` while `out_valid = 1` at index 15 → the next cycle shows `out_valid = 0`, `busy = 0`, no `done`. A following `start` restarts at index 0 with the checksum recomputed from 0.
6. **Register 0 hard-wired.** Attempt a write of 0x23456789 to reg[0], then dump → index 0 = 0, and the checksum excludes 0x23456789.

Source files
------------

// File: rtl/gpr_dumper_pkg.sv
// Shared constants and state encoding for the GPR debug dump engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package gpr_dumper_pkg;

    // One word per GPR, then Flag, then the checksum.
    localparam int         DUMP_WORDS    = 34;
    localparam logic [5:0] DUMP_IDX_FLAG = 6'd32;
    localparam logic [5:0] DUMP_IDX_CSUM = 6'(DUMP_WORDS - 1);

    typedef enum logic [1:0] {
        DUMP_IDLE  = 2'd0,
        DUMP_FETCH = 2'd1,
        DUMP_SEND  = 2'd2,
        DUMP_DONE  = 2'd3
    } dump_state_e;

endpackage : gpr_dumper_pkg

// File: rtl/gpr_dumper.sv
// Walks GPR 0-31, then Flag, then a 32-bit additive checksum, streaming 34 words.
// Latency: start edge -> out_valid after the next edge; 2 cycles per word minimum.
// Backpressure: words are held stable while out_ready is low; no timeout.
module gpr_dumper
    import gpr_dumper_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  RdAddr,
    input  logic [31:0] RdData,
    input  logic [31:0] Flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_index,
    output logic        busy,
    output logic        done
);

    dump_state_e state_q;
    logic [5:0]  idx_q;
    logic [31:0] sum_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [5:0]  out_index_q;
    logic [31:0] fetch_dat_d;

    // Read port follows the word counter; above 31 the address is don't-care.
    assign RdAddr = idx_q[4:0];

    // Select the word for the current index: GPR, then Flag, then checksum.
    always_comb begin
        fetch_dat_d = sum_q;
        if (idx_q < DUMP_IDX_FLAG) begin
            fetch_dat_d = RdData;
        end else if (idx_q == DUMP_IDX_FLAG) begin
            fetch_dat_d = Flag;
        end
    end

    // Dump sequencer: counter, checksum accumulator and registered output word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= DUMP_IDLE;
            idx_q       <= 6'd0;
            sum_q       <= 32'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_index_q <= 6'd0;
        end else begin
            case (state_q)
                DUMP_IDLE: begin
                    if (start) begin
                        idx_q   <= 6'd0;
                        sum_q   <= 32'd0;
                        state_q <= DUMP_FETCH;
                    end
                end
                DUMP_FETCH: begin
                    out_data_q  <= fetch_dat_d;
                    out_index_q <= idx_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q < DUMP_IDX_CSUM) begin
                            // The checksum word itself is never folded back in.
                            sum_q   <= sum_q + out_data_q;
                            idx_q   <= idx_q + 6'd1;
                            state_q <= DUMP_FETCH;
                        end else begin
                            state_q <= DUMP_DONE;
                        end
                    end
                end
                DUMP_DONE: begin
                    state_q <= DUMP_IDLE;
                end
                default: begin
                    state_q <= DUMP_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    // Pure state decodes: no path from out_ready to these.
    assign busy      = (state_q != DUMP_IDLE);
    assign done      = (state_q == DUMP_DONE);

endmodule : gpr_dumper
